alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Shares the single combinational Alu between NUM_REQ requesters, such as the execute stage and the address-generation unit.
- Arbitrates requests round-robin and drives the Alu operand/opcode inputs.
- Captures result and flags into a one-deep response register with valid/ready handshake.
- Owns the architectural NZCV register (apsr_flags), updated only by flag-setting requests with ARM merge semantics.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TAG_W, 4, width of requester-supplied transaction tag echoed on response

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; transfer when valid&ready at posedge
req_op  in  NUM_REQ x 4  alu_op_t per requester
req_a  in  NUM_REQ x 32  operand 1
req_b  in  NUM_REQ x 32  operand 2
req_set_flags  in  NUM_REQ  request updates apsr_flags (S-suffix)
req_tag  in  NUM_REQ x TAG_W  opaque tag
alu_opcode  out  4  to Alu
alu_in1  out  32  to Alu data_in1
alu_in2  out  32  to Alu data_in2
alu_result  in  32  from Alu data_out
alu_flags  in  4  from Alu flags_out (alu_flags_t)
resp_valid  out  1  response register full
resp_ready  in  1  consumer accept
resp_id  out  $clog2(NUM_REQ)  index of granted requester
resp_tag  out  TAG_W  echoed tag
resp_data  out  32  registered result
resp_flags  out  4  merged NZCV as written (or would be written) to APSR
resp_err  out  1  opcode not supported
apsr_flags  out  4  architectural NZCV register

Behaviour:
- Reset (async, rst=1): resp_valid=0, resp_data=0, resp_flags=0, resp_err=0, resp_id=0, resp_tag=0, apsr_flags=0, rr_ptr=0, req_ready=0.
- FSM has two states: EMPTY and FULL.
  - can_accept = (state==EMPTY) | (resp_valid & resp_ready).
  - EMPTY: any valid -> accept -> FULL.
  - FULL: resp_ready & any valid -> accept, stay FULL. resp_ready & no valid -> EMPTY. No resp_ready -> hold; all outputs stable.
- Arbitration:
  - Grant = first valid requester at or after rr_ptr (circular).
  - req_ready[i] = can_accept & grant[i]; at most one bit high.
  - On accept, rr_ptr <= grant_idx+1 mod NUM_REQ.
  - Combinational from req_valid, as required for a ready output.
- Alu drive:
  - alu_opcode/in1/in2 = granted request's op/a/b; when no grant, drive the op/a/b of index rr_ptr.
  - Alu is combinational; result sampled at the accepting edge.
- Latency: 1 cycle, accept edge -> resp_valid. Throughput: 1 op/cycle while resp_ready=1.
- Flag merge (merged NZCV):
  - ALU_ADD/ALU_SUB: merged = alu_flags.
  - ALU_AND/ORR/EOR: N,Z from alu_flags; C,V = current apsr_flags.C/V (preserved, ARM semantics).
  - resp_flags = merged.
  - apsr_flags <= merged at accept edge only if req_set_flags.
- Unsupported opcode (>ALU_EOR):
  - resp_data = alu_result (0xFFFFFFFF), resp_err=1, resp_flags = apsr_flags.
  - apsr_flags unchanged even if set_flags.
- Back-to-back flag setters: the second request's merge uses apsr_flags already updated by the first (register updated at the first accept edge).
- Requester dropping valid without ready is legal; no state change.
- Reset mid-operation: pending response discarded, no spurious resp_valid after release.

Optional Feature:
ALU_ISSUE_FIXED_PRIO_EN
- Defined: fixed priority; lowest index wins; rr_ptr removed.
- Undefined: round-robin as above.

Decomposition:
- alu_pkg gains ALU_NUM_OPS=5, function alu_op_is_logical(alu_op_t), typedef alu_req_t {op, a, b, set_flags, tag}.
- Sub-module rr_arbiter (req vector, ptr -> one-hot grant, index); instantiated unless ALU_ISSUE_FIXED_PRIO_EN.
- Alu instantiated by the parent, not inside this block.

Test Plan:
- Single ADD: req0 ADD 0xFFFFFFFF+0x1, set_flags=1 -> next cycle resp_valid, data=0, flags=0110 (Z,C), apsr_flags=0110, resp_id=0.
- Logical preserve: ADDS 0x80000000+0x80000000 (apsr NZCV=0111), then ANDS 0xFFFFFFFF&0xFFFFFFFF -> resp_flags=1011, apsr=1011 (N set, C,V kept).
- Round-robin: req0 and req1 continuously valid, resp_ready=1 -> resp_id alternates 0,1,0,1. With ALU_ISSUE_FIXED_PRIO_EN -> always 0.
- Backpressure: resp_ready=0 for 3 cycles while FULL -> req_ready=0 and resp_* stable; resp_ready=1 -> same-cycle accept of the next request, no bubble.
- Unsupported op 4'hF, set_flags=1, apsr=0100 -> resp_err=1, data=0xFFFFFFFF, apsr stays 0100.
- Reset asserted while FULL -> resp_valid=0 and apsr_flags=0 immediately (asynchronous).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared Alu types: opcode and NZCV encodings, request bundle, opcode helpers.
// No logic or latency; pure declarations.
// Backpressure: not applicable.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_ORR = 4'd3,
        ALU_EOR = 4'd4
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    localparam int ALU_NUM_OPS    = 5;
    localparam int ALU_TAG_W_MAX  = 8;

    typedef struct packed {
        alu_op_t                  op;
        logic [31:0]              a;
        logic [31:0]              b;
        logic                     set_flags;
        logic [ALU_TAG_W_MAX-1:0] tag;
    } alu_req_t;

    function automatic logic alu_op_is_logical(alu_op_t op);
        return (op == ALU_AND) || (op == ALU_ORR) || (op == ALU_EOR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, circularly.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one combinational Alu among NUM_REQ requesters; owns APSR NZCV. ALU_ISSUE_FIXED_PRIO_EN selects fixed priority.
// Latency: 1 cycle from accept edge to resp_valid; 1 op/cycle while resp_ready=1.
// Backpressure: one-deep response register; req_ready drops while it is full and not being drained.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*4-1:0]          req_op,
    input  logic [NUM_REQ*32-1:0]         req_a,
    input  logic [NUM_REQ*32-1:0]         req_b,
    input  logic [NUM_REQ-1:0]            req_set_flags,
    input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
    output logic [3:0]                    alu_opcode,
    output logic [31:0]                   alu_in1,
    output logic [31:0]                   alu_in2,
    input  logic [31:0]                   alu_result,
    input  logic [3:0]                    alu_flags,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [TAG_W-1:0]              resp_tag,
    output logic [31:0]                   resp_data,
    output logic [3:0]                    resp_flags,
    output logic                          resp_err,
    output logic [3:0]                    apsr_flags
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic               state_q, state_d;
    logic [IDX_W-1:0]   resp_id_q, resp_id_d;
    logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
    logic [31:0]        resp_data_q, resp_data_d;
    alu_flags_t         resp_flags_q, resp_flags_d;
    logic               resp_err_q, resp_err_d;
    alu_flags_t         apsr_q, apsr_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   base_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               can_accept;
    logic               any_vld;
    logic               accept;

    logic [3:0]         sel_op;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic               sel_sf;
    logic [TAG_W-1:0]   sel_tag;
    logic               op_ok;
    alu_flags_t         af;
    alu_flags_t         merged;

`ifdef ALU_ISSUE_FIXED_PRIO_EN
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

    assign base_idx = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign base_idx = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // rst gates ready so nothing is offered while the block is held in reset
    assign can_accept = !rst && ((state_q == ST_EMPTY) || resp_ready);
    assign any_vld    = |req_valid;
    assign accept     = can_accept && any_vld;
    assign req_ready  = can_accept ? grant : '0;

    assign sel_idx = any_vld ? grant_idx : base_idx;
    assign sel_op  = req_op[int'(sel_idx)*4 +: 4];
    assign sel_a   = req_a[int'(sel_idx)*32 +: 32];
    assign sel_b   = req_b[int'(sel_idx)*32 +: 32];
    assign sel_sf  = req_set_flags[sel_idx];
    assign sel_tag = req_tag[int'(sel_idx)*TAG_W +: TAG_W];

    assign alu_opcode = sel_op;
    assign alu_in1    = sel_a;
    assign alu_in2    = sel_b;

    assign op_ok = (sel_op < 4'(ALU_NUM_OPS));
    assign af    = alu_flags_t'(alu_flags);

    // Logical ops keep the architectural carry and overflow
    always_comb begin
        merged = af;
        if (!op_ok) begin
            merged = apsr_q;
        end else if (alu_op_is_logical(alu_op_t'(sel_op))) begin
            merged.c = apsr_q.c;
            merged.v = apsr_q.v;
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_id_d    = resp_id_q;
        resp_tag_d   = resp_tag_q;
        resp_data_d  = resp_data_q;
        resp_flags_d = resp_flags_q;
        resp_err_d   = resp_err_q;
        apsr_d       = apsr_q;
        if (accept) begin
            state_d      = ST_FULL;
            resp_id_d    = grant_idx;
            resp_tag_d   = sel_tag;
            resp_data_d  = alu_result;
            resp_flags_d = merged;
            resp_err_d   = !op_ok;
            if (sel_sf && op_ok) begin
                apsr_d = merged;
            end
        end else if ((state_q == ST_FULL) && resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            resp_id_q    <= '0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
            resp_err_q   <= 1'b0;
            apsr_q       <= '0;
        end else begin
            state_q      <= state_d;
            resp_id_q    <= resp_id_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
            resp_flags_q <= resp_flags_d;
            resp_err_q   <= resp_err_d;
            apsr_q       <= apsr_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_id    = resp_id_q;
    assign resp_tag   = resp_tag_q;
    assign resp_data  = resp_data_q;
    assign resp_flags = resp_flags_q;
    assign resp_err   = resp_err_q;
    assign apsr_flags = apsr_q;

endmodule
